// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: reads a frame once in raster order, writes interior edge map.
// Optional SOBEL_MAG_OUT_EN: write saturated gradient magnitude instead of a binary edge flag.
module sobel_stream #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int COLOR_BITS = 4,
  parameter int ADDR_BITS  = 19,
  parameter int READ_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COLOR_BITS+4:0]   threshold,
  output logic                    busy,
  output logic                    done,
  input  logic [3*COLOR_BITS-1:0] pixel_data,
  output logic [ADDR_BITS-1:0]    pic_memory_addr,
  output logic                    edge_we,
  output logic [ADDR_BITS-1:0]    edge_memory_addr,
  output logic [COLOR_BITS-1:0]   is_edge
);
  localparam int CB = COLOR_BITS;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = CB + 4;
  localparam int MW = CB + 5;
  localparam logic [XW-1:0]        X_LAST  = XW'(WIDTH - 1);
  localparam logic [ADDR_BITS-1:0] LAST_RD = ADDR_BITS'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] LAST_WR = ADDR_BITS'((HEIGHT - 1) * WIDTH - 2);
  localparam logic [ADDR_BITS-1:0] CTR_OFS = ADDR_BITS'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [MW-1:0] thr;
  logic last_rd, last_wr;

  assign last_rd = (pic_memory_addr == LAST_RD);
  assign last_wr = edge_we && (edge_memory_addr == LAST_WR);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)   state_nx = READ;
      READ:    if (last_rd) state_nx = DRAIN;
      DRAIN:   if (last_wr) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Raster address generator; threshold is latched only when a frame is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      pic_memory_addr <= '0;
      rd_x            <= '0;
      rd_y            <= '0;
      thr             <= '0;
    end else if (state == IDLE && start) begin
      pic_memory_addr <= '0;
      rd_x            <= '0;
      rd_y            <= '0;
      thr             <= threshold;
    end else if (state == READ && !last_rd) begin
      pic_memory_addr <= pic_memory_addr + 1'b1;
      if (rd_x == X_LAST) begin
        rd_x <= '0;
        rd_y <= rd_y + 1'b1;
      end else begin
        rd_x <= rd_x + 1'b1;
      end
    end
  end

  // vld_pipe[i]: an address was issued i cycles ago
  logic [READ_LAT:1]                vld_pipe;
  logic [READ_LAT:1][XW-1:0]        x_pipe;
  logic [READ_LAT:1][YW-1:0]        y_pipe;
  logic [READ_LAT:1][ADDR_BITS-1:0] a_pipe;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= (state == READ);
      for (int i = 2; i <= READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    x_pipe[1] <= rd_x;
    y_pipe[1] <= rd_y;
    a_pipe[1] <= pic_memory_addr;
    for (int i = 2; i <= READ_LAT; i++) begin
      x_pipe[i] <= x_pipe[i-1];
      y_pipe[i] <= y_pipe[i-1];
      a_pipe[i] <= a_pipe[i-1];
    end
  end

  logic                 cap;
  logic [XW-1:0]        cx;
  logic [YW-1:0]        cy;
  logic [ADDR_BITS-1:0] ca;
  logic [CB-1:0]        pr, pg, pb, luma;

  assign cap = vld_pipe[READ_LAT];
  assign cx  = x_pipe[READ_LAT];
  assign cy  = y_pipe[READ_LAT];
  assign ca  = a_pipe[READ_LAT];
  assign {pr, pg, pb} = pixel_data;
  assign luma = (pr >> 2) + (pg >> 1) + (pg >> 3) + (pb >> 3);

  // lb0 holds row y-1, lb1 row y-2; win[row][col], col 2 is the newest column
  logic [CB-1:0]              lb0 [WIDTH];
  logic [CB-1:0]              lb1 [WIDTH];
  logic [2:0][2:0][CB-1:0]    win;
  logic                       win_vld;
  logic [ADDR_BITS-1:0]       win_addr;

  always_ff @(posedge clk) begin
    if (cap) begin
      lb1[cx] <= lb0[cx];
      lb0[cx] <= luma;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[cx];
      win[1][2] <= lb0[cx];
      win[2][2] <= luma;
    end
  end

  // A full window only exists once two columns and two rows precede the pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld  <= 1'b0;
      win_addr <= '0;
    end else begin
      win_vld  <= cap && (cx >= XW'(2)) && (cy >= YW'(2));
      win_addr <= ca - CTR_OFS;
    end
  end

  logic [SW-1:0] gx_p, gx_n, gy_p, gy_n, gx, gy, ax, ay;
  logic [MW-1:0] mag, mag_q;
  logic          mag_vld;
  logic [ADDR_BITS-1:0] mag_addr;
  logic [CB-1:0] edge_val;

  assign gx_p = SW'(win[0][2]) + (SW'(win[1][2]) << 1) + SW'(win[2][2]);
  assign gx_n = SW'(win[0][0]) + (SW'(win[1][0]) << 1) + SW'(win[2][0]);
  assign gy_p = SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(win[2][2]);
  assign gy_n = SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(win[0][2]);
  assign gx   = gx_p - gx_n;
  assign gy   = gy_p - gy_n;
  assign ax   = gx[SW-1] ? (~gx + SW'(1)) : gx;
  assign ay   = gy[SW-1] ? (~gy + SW'(1)) : gy;
  assign mag  = MW'(ax) + MW'(ay);

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_vld  <= 1'b0;
      mag_q    <= '0;
      mag_addr <= '0;
    end else begin
      mag_vld  <= win_vld;
      mag_q    <= mag;
      mag_addr <= win_addr;
    end
  end

`ifdef SOBEL_MAG_OUT_EN
  localparam logic [CB-1:0] PIX_MAX = '1;
  assign edge_val = (mag_q > thr) ? ((mag_q > MW'(PIX_MAX)) ? PIX_MAX : mag_q[CB-1:0]) : '0;
`else
  assign edge_val = (mag_q > thr) ? '1 : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_we          <= 1'b0;
      edge_memory_addr <= '0;
      is_edge          <= '0;
    end else begin
      edge_we          <= mag_vld;
      edge_memory_addr <= mag_addr;
      is_edge          <= edge_val;
    end
  end
endmodule
